systolic_skew_feeder: RTL and testbench

Input-edge stage of the systolic array. It accepts one LANES-wide operand vector per cycle over a valid/ready handshake and drives the array's west edge with the diagonal skew the PE grid requires: lane i is delayed i+1 cycles. After the tile's last vector it flushes the skew pipeline, then pulses `tile_done`. Each lane carries its own valid bit, so input bubbles propagate as skewed bubbles rather than stalling the array.

---
 rtl/systolic_skew_feeder_pkg.sv | 18 +
 rtl/systolic_skew_feeder_skew_lane.sv | 35 +++
 rtl/systolic_skew_feeder.sv | 88 ++++++++
 tb/tb_systolic_skew_feeder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic west-edge skew feeder.
package systolic_skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// DEPTH-stage data+valid shift register for one skewed array row.
module skew_lane #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        stage_data[i] <= '0;
      stage_valid <= '0;
    end else begin
      stage_data[0]  <= load_data;
      stage_valid[0] <= load_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage_data[i]  <= stage_data[i-1];
        stage_valid[i] <= stage_valid[i-1];
      end
    end
  end

  assign data  = stage_data[DEPTH-1];
  assign valid = stage_valid[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Systolic array west-edge feeder: diagonal skew, tile flush, done pulse.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic               in_last,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]   out_valid,
  output logic               tile_done,
  output logic               busy
);

  localparam int CW = clog2(LANES);

  state_t          state;
  state_t          state_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  logic            accept;
  logic            done_d;

  assign in_ready = (state != FLUSH);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = FLUSH;
            cnt_d   = CW'(LANES - 2);
          end else begin
            state_d = STREAM;
          end
        end
      end
      FLUSH: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulse during the final flush cycle
  assign done_d = (state_d == FLUSH) && (cnt_d == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      tile_done <= done_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] load_data;

    assign load_data = accept ? in_data[i*WIDTH +: WIDTH] : '0;

    skew_lane #(
      .WIDTH (WIDTH),
      .DEPTH (i + 1)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .load_data  (load_data),
      .load_valid (accept),
      .data       (out_data[i*WIDTH +: WIDTH]),
      .valid      (out_valid[i])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: stimulus table plus per-lane scoreboard.
module tb_systolic_skew_feeder;

  localparam int W = 16;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [L*W-1:0] in_data = '0;
  logic           in_last = 1'b0;
  logic [L*W-1:0] out_data;
  logic [L-1:0]   out_valid;
  logic           tile_done;
  logic           busy;

  systolic_skew_feeder #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .tile_done (tile_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [W-1:0] data;
  } ent_t;

  typedef struct {
    logic       v;
    logic       l;
    logic [63:0] d;
    logic       rdy;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  ent_t lane_q [L][$];
  int   done_q [$];
  vec_t tbl [$];
  int   fl_lo = -100;
  int   fl_hi = -100;
  int   bz_lo = 1 << 30;
  int   bz_hi = 1 << 30;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               name, cyc, act, req);
    end
  endtask

  function automatic logic m_ready();
    return !(cyc >= fl_lo && cyc <= fl_hi);
  endfunction

  task automatic check_outputs();
    logic         ev;
    logic [W-1:0] ed;
    logic         dn;
    for (int i = 0; i < L; i++) begin
      ev = 1'b0;
      ed = '0;
      if (lane_q[i].size() > 0 && lane_q[i][0].cyc == cyc) begin
        ev = 1'b1;
        ed = lane_q[i][0].data;
        void'(lane_q[i].pop_front());
      end
      chk($sformatf("lane%0d", i),
          {out_valid[i], out_data[i*W +: W]}, {ev, ed});
    end
    dn = 1'b0;
    if (done_q.size() > 0 && done_q[0] == cyc) begin
      dn = 1'b1;
      void'(done_q.pop_front());
    end
    chk("tile_done", tile_done, dn);
    chk("in_ready", in_ready, m_ready());
    chk("busy", busy, (cyc >= bz_lo && cyc <= bz_hi));
  endtask

  task automatic tick(input logic v, input logic l, input logic [63:0] d);
    logic acc;
    logic busy_old;
    in_valid = v;
    in_last  = l;
    in_data  = d;
    acc      = v && m_ready();
    busy_old = (cyc >= bz_lo && cyc <= bz_hi);
    @(posedge clk);
    cyc++;
    if (acc) begin
      for (int i = 0; i < L; i++)
        lane_q[i].push_back('{cyc + i, d[i*W +: W]});
      if (!busy_old) begin
        bz_lo = cyc;
        bz_hi = 1 << 30;
      end
      if (l) begin
        fl_lo = cyc;
        fl_hi = cyc + L - 2;
        bz_hi = cyc + L - 2;
        done_q.push_back(cyc + L - 2);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic void add(input logic v, input logic l,
                              input logic [63:0] d, input logic rdy);
    tbl.push_back('{v, l, d, rdy});
  endfunction

  initial begin
    add(0, 0, 64'h0, 1);
    add(0, 0, 64'h0, 1);
    add(1, 1, 64'h0004_0003_0002_0001, 1);
    repeat (3) add(0, 0, 64'h0, 0);
    repeat (2) add(0, 0, 64'h0, 1);
    add(1, 0, 64'h1103_1102_1101_1100, 1);
    add(1, 0, 64'h1203_1202_1201_1200, 1);
    add(1, 0, 64'h1303_1302_1301_1300, 1);
    add(1, 1, 64'h1403_1402_1401_1400, 1);
    repeat (3) add(0, 0, 64'h0, 0);
    repeat (2) add(0, 0, 64'h0, 1);
    add(1, 0, 64'h2103_2102_2101_2100, 1);
    add(1, 0, 64'h2203_2202_2201_2200, 1);
    add(0, 0, 64'hDEAD_DEAD_DEAD_DEAD, 1);
    add(1, 0, 64'h2303_2302_2301_2300, 1);
    add(1, 1, 64'h2403_2402_2401_2400, 1);
    repeat (3) add(0, 0, 64'h0, 0);
    repeat (2) add(0, 0, 64'h0, 1);
    add(1, 1, 64'h3103_3102_3101_3100, 1);
    repeat (3) add(1, 1, 64'h3203_3202_3201_3200, 0);
    add(1, 1, 64'h3203_3202_3201_3200, 1);
    repeat (3) add(0, 0, 64'h0, 0);
    repeat (2) add(0, 0, 64'h0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_tile_done", tile_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      chk($sformatf("tbl_ready%0d", k), in_ready, tbl[k].rdy);
      tick(tbl[k].v, tbl[k].l, tbl[k].d);
    end

    tick(1, 1, 64'h00AA_00BB_00CC_00DD);
    tick(0, 0, 64'h0);
    #2 reset = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, '0);
    chk("abort_out_data", out_data, '0);
    chk("abort_tile_done", tile_done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    for (int i = 0; i < L; i++) lane_q[i].delete();
    done_q.delete();
    fl_lo = -100;
    fl_hi = -100;
    bz_lo = 1 << 30;
    bz_hi = 1 << 30;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
    reset = 1'b1;

    tick(0, 0, 64'h0);
    tick(1, 1, 64'h0004_0003_0002_0001);
    chk("rerun_lane0", {out_valid[0], out_data[15:0]}, 17'h1_0001);
    repeat (6) tick(0, 0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
